// File: rtl/dual_issue_hazard_ctrl.sv
// dual_issue_hazard_ctrl
// Central hazard/flush sequencer for the dual-issue front end. Resolves
// execute-stage mispredicts, decode-stage jumps/JRs, the slot-2 jump behind
// an unresolved slot-1 branch, and slot-1 load-use hazards into one
// consistent set of ID1->ID2 register strobes plus PC control.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module dual_issue_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int PEND_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jump1_D,
    input  logic             jump2_D,
    input  logic             jr1_D,
    input  logic             jr2_D,
    input  logic             branch1_D,
    input  logic             br_resolve_E,
    input  logic             br_mispredict_E,
    input  logic             br_slot_E,
    input  logic             ld_valid_E,
    input  logic [REG_W-1:0] ld_rd_E,
    input  logic [REG_W-1:0] rs1_D,
    input  logic [REG_W-1:0] rt1_D,
    output logic             flush1_B,
    output logic             flush2_B,
    output logic             flush1_JR,
    output logic             flush2_JR,
    output logic             flush_JB,
    output logic             stall_outer,
    output logic             pc_hold,
    output logic             jump_redirect
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LDSTALL = 2'd1,
        BR_PEND = 2'd2
    } state_t;

    // Last pend-counter value before the wait is forcibly released.
    localparam logic [2:0] PEND_LAST = 3'(PEND_MAX - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] pend_cnt_reg;
    logic [2:0] pend_cnt_next;

    logic mispredict;
    logic ld_hazard;

    // Ungated strobes; the reset gate below forces them low asynchronously.
    logic flush1_b_comb;
    logic flush2_b_comb;
    logic flush1_jr_comb;
    logic flush2_jr_comb;
    logic flush_jb_comb;
    logic stall_outer_comb;
    logic pc_hold_comb;
    logic jump_redirect_comb;

    assign mispredict = br_resolve_E & br_mispredict_E;
    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign ld_hazard  = ld_valid_E && (ld_rd_E != '0) &&
                        ((ld_rd_E == rs1_D) || (ld_rd_E == rt1_D));

    // Prioritised strobe decode and next-state selection.
    always_comb begin
        flush1_b_comb      = 1'b0;
        flush2_b_comb      = 1'b0;
        flush1_jr_comb     = 1'b0;
        flush2_jr_comb     = 1'b0;
        flush_jb_comb      = 1'b0;
        stall_outer_comb   = 1'b0;
        pc_hold_comb       = 1'b0;
        jump_redirect_comb = 1'b0;
        state_next         = IDLE;
        pend_cnt_next      = 3'd0;

        if (mispredict) begin
            // A wrong-path flush overrides everything, from any state.
            flush1_b_comb = ~br_slot_E;
            flush2_b_comb = br_slot_E;
        end else begin
            case (state_reg)
                BR_PEND: begin
                    // Hold fetch until the slot-1 branch resolves or the wait expires;
                    // decode-side events are ignored because ID1 is frozen.
                    pc_hold_comb = 1'b1;
                    if (br_resolve_E || (pend_cnt_reg == PEND_LAST)) begin
                        jump_redirect_comb = 1'b1;
                        state_next         = IDLE;
                    end else begin
                        state_next    = BR_PEND;
                        pend_cnt_next = pend_cnt_reg + 3'd1;
                    end
                end
                default: begin
                    // IDLE and LDSTALL share jump servicing; only IDLE may stall,
                    // so one instruction is never stalled twice.
                    if (jr1_D) begin
                        flush1_jr_comb     = 1'b1;
                        jump_redirect_comb = 1'b1;
                    end else if (jr2_D) begin
                        flush2_jr_comb     = 1'b1;
                        jump_redirect_comb = 1'b1;
                    end else if (jump2_D && branch1_D) begin
                        flush_jb_comb = 1'b1;
                        pc_hold_comb  = 1'b1;
                        state_next    = BR_PEND;
                    end else if (jump1_D || jump2_D) begin
                        jump_redirect_comb = 1'b1;
                    end else if ((state_reg == IDLE) && ld_hazard) begin
                        stall_outer_comb = 1'b1;
                        pc_hold_comb     = 1'b1;
                        state_next       = LDSTALL;
                    end
                end
            endcase
        end
    end

    // Outputs drop to zero the moment reset is asserted, even mid-wait.
    assign flush1_B      = reset & flush1_b_comb;
    assign flush2_B      = reset & flush2_b_comb;
    assign flush1_JR     = reset & flush1_jr_comb;
    assign flush2_JR     = reset & flush2_jr_comb;
    assign flush_JB      = reset & flush_jb_comb;
    assign stall_outer   = reset & stall_outer_comb;
    assign pc_hold       = reset & pc_hold_comb;
    assign jump_redirect = reset & jump_redirect_comb;

    // State and pend-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            pend_cnt_reg <= 3'd0;
        end else begin
            state_reg    <= state_next;
            pend_cnt_reg <= pend_cnt_next;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic any_flush;
    assign any_flush = flush1_B | flush2_B | flush1_JR | flush2_JR | flush_JB;

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((stall_outer || pc_hold) && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (any_flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

endmodule
